// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_t;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] offset);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = offset[0];
      2'b10:   mis = |offset[1:0];
      2'b11:   mis = |offset;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and byte-lane merge for
// read-modify-write stores. Purely combinational.
module lsu_align (
  input  logic [63:0] word_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] load_o,
  output logic [63:0] merged_o
);

  logic [5:0]  shamt_s;
  logic [63:0] shifted_s;
  logic [63:0] size_mask_s;
  logic        sext_s;

  assign shamt_s = {offset_i, 3'b000};

  // Shift the addressed lane down, extend it, and merge store bytes at the same lane.
  always_comb begin
    shifted_s   = word_i >> shamt_s;
    sext_s      = ~funct3_i[2];
    size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
    load_o      = shifted_s;
    case (funct3_i[1:0])
      2'b00: begin
        size_mask_s = 64'h0000_0000_0000_00FF;
        load_o      = {{56{sext_s & shifted_s[7]}}, shifted_s[7:0]};
      end
      2'b01: begin
        size_mask_s = 64'h0000_0000_0000_FFFF;
        load_o      = {{48{sext_s & shifted_s[15]}}, shifted_s[15:0]};
      end
      2'b10: begin
        size_mask_s = 64'h0000_0000_FFFF_FFFF;
        load_o      = {{32{sext_s & shifted_s[31]}}, shifted_s[31:0]};
      end
      default: begin
        size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        load_o      = shifted_s;
      end
    endcase
    merged_o = (word_i & ~(size_mask_s << shamt_s)) | ((wdata_i & size_mask_s) << shamt_s);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit: turns byte-addressed RV64 accesses into whole
// doubleword memory reads/writes, with read-modify-write for narrow stores.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 256,
  parameter int unsigned ROM_SIZE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic        mem_rd_enable,
  input  logic [63:0] mem_rd_data
);

  lsu_state_t  state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [63:0] wr_data_q, wr_data_d;

  logic [28:0] word_s;
  logic        fault_s;
  logic [63:0] load_s;
  logic [63:0] merged_s;

  lsu_align u_align (
    .word_i   (mem_rd_data),
    .wdata_i  (req_wdata),
    .offset_i (req_addr[2:0]),
    .funct3_i (req_funct3),
    .load_o   (load_s),
    .merged_o (merged_s)
  );

  assign word_s = req_addr[31:3];

  // Fault classification of the request currently presented.
  always_comb begin
    fault_s = (req_funct3 == F3_ILL)
            | (req_store & req_funct3[2])
            | is_misaligned(req_funct3, req_addr[2:0])
            | (word_s >= 29'(MEM_SIZE))
            | (req_store & (word_s < 29'(ROM_SIZE)));
  end

  // Next-state, memory strobes and response capture.
  always_comb begin
    state_d       = state_q;
    resp_valid_d  = 1'b0;
    resp_fault_d  = 1'b0;
    resp_rdata_d  = 64'd0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    req_ready     = 1'b0;
    mem_addr      = req_addr;
    mem_wr_data   = req_wdata;
    mem_wr_enable = 1'b0;
    mem_rd_enable = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (fault_s) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (!req_store) begin
            mem_rd_enable = 1'b1;
            resp_valid_d  = 1'b1;
            resp_rdata_d  = load_s;
          end else if (req_funct3[1:0] == F3_D[1:0]) begin
            mem_wr_enable = 1'b1;
            resp_valid_d  = 1'b1;
          end else begin
            // Narrow store: read now, write the merged word next cycle.
            mem_rd_enable = 1'b1;
            wr_addr_d     = req_addr;
            wr_data_d     = merged_s;
            state_d       = WRITE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        mem_addr      = wr_addr_q;
        mem_wr_data   = wr_data_q;
        mem_wr_enable = 1'b1;
        resp_valid_d  = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected responses, writes and
// signal probes; a single monitor process pops and compares them.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_enable;
  logic        mem_rd_enable;
  logic [63:0] mem_rd_data;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable),
    .mem_rd_enable(mem_rd_enable), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h9E37_79B9;
    case (i)
      3:       return 64'h8877_6655_4433_2211;
      4:       return 64'h0;
      6:       return 64'h1111_2222_3333_4444;
      default: return {v, ~v};
    endcase
  endfunction

  logic [63:0] mem [256];
  logic [63:0] ref_mem [256];
  logic        init_en = 1'b1;

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_wr_enable) begin
      mem[mem_addr[10:3]] <= mem_wr_data;
    end
  end
  assign mem_rd_data = mem[mem_addr[10:3]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic fault; logic [63:0] rdata; logic [31:0] cyc; } resp_t;
  typedef struct packed { logic [7:0] idx; logic [63:0] data; logic [31:0] cyc; } wr_t;
  typedef struct packed { logic [2:0] sel; logic [63:0] exp; logic [31:0] cyc; } probe_t;

  resp_t  resp_q[$];
  wr_t    wr_q[$];
  probe_t probe_q[$];
  logic   done = 1'b0;
  int     checks = 0;
  int     errors = 0;

  function automatic logic [63:0] probe_val(input logic [2:0] sel);
    case (sel)
      3'd0:    return 64'(req_ready);
      3'd1:    return 64'(resp_valid);
      3'd2:    return 64'(mem_wr_enable);
      3'd3:    return mem[6];
      3'd4:    return resp_rdata;
      3'd5:    return 64'(resp_fault);
      3'd6:    return 64'(mem_rd_enable);
      default: return 64'd0;
    endcase
  endfunction

  // Single checking process: probes, memory writes, responses, end of run.
  always @(negedge clk) begin : monitor
    probe_t p;
    resp_t  r;
    wr_t    w;
    logic [63:0] act;
    #2;
    while (probe_q.size() > 0 && probe_q[0].cyc <= 32'(cyc)) begin
      p = probe_q.pop_front();
      act = probe_val(p.sel);
      checks++;
      if (p.cyc != 32'(cyc) || act !== p.exp) begin
        errors++;
        $display("FAIL probe sel=%0d cyc=%0d got %h expected %h at cyc %0d", p.sel, cyc, act, p.exp, p.cyc);
      end
    end
    if (mem_wr_enable) begin
      checks++;
      if (mem_rd_enable) begin
        errors++;
        $display("FAIL strobe_overlap got rd=1 wr=1 expected at most one");
      end
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got idx=%0d data=%h expected no write", mem_addr[10:3], mem_wr_data);
      end else begin
        w = wr_q.pop_front();
        if (mem_addr[10:3] !== w.idx || mem_wr_data !== w.data || 32'(cyc) != w.cyc) begin
          errors++;
          $display("FAIL write got idx=%0d data=%h cyc=%0d expected idx=%0d data=%h cyc=%0d",
                   mem_addr[10:3], mem_wr_data, cyc, w.idx, w.data, w.cyc);
        end
      end
    end
    if (resp_valid) begin
      checks++;
      if (resp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got rdata=%h fault=%b expected none", resp_rdata, resp_fault);
      end else begin
        r = resp_q.pop_front();
        if (resp_rdata !== r.rdata || resp_fault !== r.fault || 32'(cyc) != r.cyc) begin
          errors++;
          $display("FAIL resp got rdata=%h fault=%b cyc=%0d expected rdata=%h fault=%b cyc=%0d",
                   resp_rdata, resp_fault, cyc, r.rdata, r.fault, r.cyc);
        end
      end
    end
    if (done) begin
      checks++;
      if (resp_q.size() != 0 || wr_q.size() != 0 || probe_q.size() != 0) begin
        errors++;
        $display("FAIL drain got resp=%0d wr=%0d probe=%0d pending expected 0", resp_q.size(), wr_q.size(), probe_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no end of run expected finish");
    $fatal(1, "watchdog");
  end

  // Issue one request; expectations are pushed at the accepting cycle.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [63:0] wd, input logic ef, input logic [63:0] er,
                      input logic haswr, input logic [63:0] ewd, input logic rsp,
                      output int acc);
    int  n;
    logic dstore;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) probe_q.push_back('{3'd0, 64'd1, 32'(cyc)});
    acc = cyc + 1;
    dstore = (f3[1:0] == 2'b11);
    if (rsp) resp_q.push_back('{ef, er, (haswr && !dstore) ? 32'(acc + 1) : 32'(acc)});
    if (haswr) begin
      wr_q.push_back('{a[10:3], ewd, dstore ? 32'(acc - 1) : 32'(acc)});
      ref_mem[a[10:3]] = ewd;
    end
    @(posedge clk);
  endtask

  // Reference-model request: computes fault, load value or merged word bytewise.
  task automatic model_send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [63:0] wd);
    int   size, off, acc;
    logic flt;
    logic [63:0] w, v;
    size = 1 << f3[1:0];
    off  = int'(a[2:0]);
    w    = ref_mem[a[10:3]];
    flt  = (f3 == 3'b111) || (st && f3[2]) || (off % size != 0) ||
           (a[31:3] >= 29'd256) || (st && a[31:3] < 29'd2);
    v = 64'd0;
    if (flt) begin
      send(st, f3, a, wd, 1'b1, 64'd0, 1'b0, 64'd0, 1'b1, acc);
    end else if (!st) begin
      for (int b = 0; b < size; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
      if (!f3[2] && size < 8 && v[8*size-1]) for (int b = size; b < 8; b++) v[8*b +: 8] = 8'hFF;
      send(st, f3, a, wd, 1'b0, v, 1'b0, 64'd0, 1'b1, acc);
    end else begin
      v = w;
      for (int b = 0; b < size; b++) v[8*(off+b) +: 8] = wd[8*b +: 8];
      send(st, f3, a, wd, 1'b0, 64'd0, 1'b1, v, 1'b1, acc);
    end
  endtask

  initial begin
    int acc;
    logic st;
    logic [2:0] f3;
    int word, off;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int s = 0; s < 7; s++) if (s != 3) probe_q.push_back('{3'(s), (s == 0) ? 64'd1 : 64'd0, 32'd2});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    init_en = 1'b0;

    send(1'b0, 3'b000, 32'h1F, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 64'd0, 1'b1, acc);
    send(1'b0, 3'b100, 32'h1F, 64'd0, 1'b0, 64'h0000_0000_0000_0088, 1'b0, 64'd0, 1'b1, acc);
    send(1'b0, 3'b010, 32'h1C, 64'd0, 1'b0, 64'hFFFF_FFFF_8877_6655, 1'b0, 64'd0, 1'b1, acc);

    send(1'b1, 3'b001, 32'h22, 64'hABCD, 1'b0, 64'd0, 1'b1, 64'h0000_0000_ABCD_0000, 1'b1, acc);
    probe_q.push_back('{3'd0, 64'd0, 32'(acc)});
    probe_q.push_back('{3'd0, 64'd1, 32'(acc + 1)});

    send(1'b1, 3'b011, 32'h28, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, acc);
    send(1'b0, 3'b011, 32'h28, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b1, acc);

    send(1'b0, 3'b001, 32'h21,  64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b1, acc);
    send(1'b0, 3'b010, 32'h22,  64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b1, acc);
    send(1'b1, 3'b011, 32'h0C,  64'hDEAD, 1'b1, 64'd0, 1'b0, 64'd0, 1'b1, acc);
    send(1'b0, 3'b011, 32'h800, 64'd0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b1, acc);

    // Reset lands in the WRITE cycle of a byte store: no write, no response.
    send(1'b1, 3'b000, 32'h30, 64'h55, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, acc);
    @(negedge clk);
    req_valid = 1'b0;
    probe_q.push_back('{3'd2, 64'd0, 32'(cyc)});
    #1 rst = 1'b1;
    probe_q.push_back('{3'd0, 64'd1, 32'(cyc + 1)});
    probe_q.push_back('{3'd1, 64'd0, 32'(cyc + 1)});
    probe_q.push_back('{3'd3, 64'h1111_2222_3333_4444, 32'(cyc + 1)});
    @(negedge clk);
    #3 rst = 1'b0;

    for (int n = 0; n < 1000; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 3));
      else f3 = 3'($urandom_range(0, 6));
      word = ($urandom_range(0, 29) == 0) ? int'($urandom_range(256, 300)) : int'($urandom_range(0, 255));
      off  = int'($urandom_range(0, 7));
      if ($urandom_range(0, 9) != 0) off = off & ~((1 << f3[1:0]) - 1);
      model_send(st, f3, {word[28:0], off[2:0]}, {$urandom, $urandom});
    end

    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    done = 1'b1;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit of the MEM stage. Sits between the EX/MEM pipeline register and the 64-bit word-addressed data memory.
- Converts byte-addressed RV64 loads and stores (B/H/W/D, signed and unsigned) into whole-doubleword memory accesses.
- Sub-doubleword stores are done as read-modify-write. Misaligned, out-of-range and ROM-region stores are flagged instead of reaching memory.

Parameters:
- mem_size, 256: number of 64-bit words in data memory.
- rom_size, 2: words 0..rom_size-1 are read-only; stores there fault.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present from EX/MEM.
- req_ready  output  1  LSU can accept a request this cycle.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV64 size/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  64  store data, right-justified.
- resp_valid  output  1  one-cycle pulse: the access has completed.
- resp_rdata  output  64  extended load result; 0 for stores and faults.
- resp_fault  output  1  qualifies resp_valid: misaligned, illegal, out-of-range or ROM store.
- mem_addr  output  32  byte address to data memory.
- mem_wr_data  output  64  full doubleword to write.
- mem_wr_enable  output  1  write strobe, sampled at clk.
- mem_rd_enable  output  1  read strobe.
- mem_rd_data  input  64  combinational read data for mem_addr.

Behaviour:
- Reset state: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, all latched address/data registers 0. Memory strobes deassert immediately, since they are derived from state.
- Handshake: a request is accepted when req_valid && req_ready. req_ready = (state==IDLE). EX/MEM holds the request while req_ready=0.
- funct3 codes:
  - 000 B, 001 H, 010 W, 011 D.
  - 100 BU, 101 HU, 110 WU are loads only.
  - 111 is illegal; stores with 1xx are illegal.
- Fault checks, evaluated combinationally on acceptance:
  - misaligned: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - out-of-range: addr[31:3] >= mem_size.
  - ROM store: store with addr[31:3] < rom_size.
  - On any fault: no memory strobe; next cycle resp_valid=1, resp_fault=1, resp_rdata=0. State stays IDLE.
- Load, state IDLE, accepted:
  - Drive mem_rd_enable=1 and mem_addr=req_addr.
  - Select the lane at byte offset addr[2:0], then sign- or zero-extend.
  - Register the result into resp_rdata. resp_valid=1 the next cycle; latency 1, throughput 1 per cycle.
- Doubleword store (D), accepted:
  - mem_wr_enable=1 and mem_wr_data=req_wdata in the same cycle.
  - resp_valid the next cycle; state stays IDLE.
- Sub-doubleword store (B/H/W), accepted:
  - READ cycle (IDLE): mem_rd_enable=1. Merge req_wdata's low bytes into mem_rd_data at offset addr[2:0]. Latch the merged word and the address. Go to WRITE.
  - WRITE cycle: req_ready=0, mem_addr=latched addr, mem_wr_enable=1, mem_wr_data=merged word. Return to IDLE.
  - resp_valid on the cycle after WRITE. Total latency 2; a new request may be accepted in that cycle.
- mem_rd_enable and mem_wr_enable are never both high in one cycle.
- When idle, both strobes are 0 and mem_addr follows req_addr.
- Reset asserted during WRITE: the write is dropped (strobe falls asynchronously). No resp_valid is issued for that request.
- Back-to-back: a load immediately after a store's WRITE cycle observes the new data, because memory reads are combinational after the clock edge.

Decomposition:
- Package lsu_pkg:
  - enum lsu_state_t {IDLE, WRITE};
  - localparams for the funct3 codes (F3_B ... F3_WU).
  - function is_misaligned(funct3, addr[2:0]).
- Sub-module lsu_align (purely combinational):
  - extract: rdata, offset, funct3 -> extended load value.
  - merge: old word, wdata, offset, funct3 -> merged word.
- lsu_ctrl holds the FSM, handshake and registers.

Test Plan:
- Mem word 3 = 0x8877665544332211; LB addr 0x1F -> resp_rdata 0xFFFFFFFFFFFFFF88; LBU addr 0x1F -> 0x88; LW addr 0x1C -> 0xFFFFFFFF88776655.
- Word 4 = 0; SH 0xABCD to addr 0x22 -> req_ready low for exactly 1 cycle, single write of 0x00000000ABCD0000 to word 4, resp_valid 2 cycles after accept, resp_fault=0.
- SD 0x0123456789ABCDEF to addr 0x28 -> write in the accept cycle; a following LD at 0x28 returns the same value; resp_valid on both, one cycle apart.
- LH addr 0x21, LW addr 0x22, SD addr 0x0C (ROM word 1), LD addr 0x800 (word 256) -> each gives resp_fault=1, resp_rdata=0, and mem_wr_enable never asserts.
- Assert rst during the WRITE cycle of SB to addr 0x30 -> mem_wr_enable drops immediately, word 6 unchanged, no resp_valid, req_ready=1 after reset.
- Random mix of 1000 accesses against a reference model; check every memory write and every load result.
